// File: rtl/ysyx_25040109_axi_initiator_if.sv
// ysyx_25040109_axi_initiator_if: single-beat AXI4 AR/R/AW/W/B bundle; master = initiator, slave = memory responder
interface ysyx_25040109_axi_initiator_if #(parameter int ADDR_W = 32);
    logic              m_arvalid;
    logic              m_arready;
    logic [ADDR_W-1:0] m_araddr;
    logic [3:0]        m_arid;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_rvalid;
    logic              m_rready;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rresp;
    logic [3:0]        m_rid;
    logic              m_rlast;
    logic              m_awvalid;
    logic              m_awready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [3:0]        m_awid;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_wvalid;
    logic              m_wready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_wlast;
    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;
    logic [3:0]        m_bid;
    modport master (
        output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
        input  m_arready,
        input  m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
        output m_rready,
        output m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_wready,
        input  m_bvalid, m_bresp, m_bid,
        output m_bready
    );
    modport slave (
        input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
        output m_arready,
        output m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
        input  m_rready,
        input  m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_wready,
        output m_bvalid, m_bresp, m_bid,
        input  m_bready
    );
endinterface

// File: rtl/ysyx_25040109_axi_initiator.sv
// ysyx_25040109_axi_initiator: single-outstanding load/store req/resp to single-beat AXI4 bridge; ports: clock, reset (async high), req_*/resp_* requester side, m = AXI master bundle
module ysyx_25040109_axi_initiator #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    ysyx_25040109_axi_initiator_if.master m
);
    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, RESP} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done, aw_ok, w_ok;
    assign req_ready   = state == IDLE;
    assign resp_valid  = state == RESP;
    assign m.m_arvalid = state == RD_AR;
    assign m.m_rready  = state == RD_R;
    assign m.m_awvalid = state == WR_AWW && !aw_done;
    assign m.m_wvalid  = state == WR_AWW && !w_done;
    assign m.m_bready  = state == WR_B;
    assign m.m_araddr  = addr_q;
    assign m.m_awaddr  = addr_q;
    assign m.m_arsize  = size_q;
    assign m.m_awsize  = size_q;
    assign m.m_arid    = AXI_ID;
    assign m.m_awid    = AXI_ID;
    assign m.m_arlen   = 8'd0;
    assign m.m_awlen   = 8'd0;
    assign m.m_arburst = 2'b01;
    assign m.m_awburst = 2'b01;
    assign m.m_wdata   = wdata_q;
    assign m.m_wstrb   = wstrb_q;
    assign m.m_wlast   = 1'b1;
    // A channel counts as done once its handshake has happened, this cycle or earlier
    assign aw_ok = aw_done || (m.m_awvalid && m.m_awready);
    assign w_ok  = w_done || (m.m_wvalid && m.m_wready);
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = req_valid ? (req_wen ? WR_AWW : RD_AR) : IDLE;
            RD_AR:   state_n = m.m_arready ? RD_R : RD_AR;
            RD_R:    state_n = m.m_rvalid ? RESP : RD_R;
            WR_AWW:  state_n = (aw_ok && w_ok) ? WR_B : WR_AWW;
            WR_B:    state_n = m.m_bvalid ? RESP : WR_B;
            RESP:    state_n = resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state <= state_n;
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (state == RD_R && m.m_rvalid) begin
                resp_rdata <= m.m_rdata;
                resp_err   <= (m.m_rresp != 2'b00) || (m.m_rid != AXI_ID) || !m.m_rlast;
            end
            if (state == WR_B && m.m_bvalid) begin
                resp_rdata <= '0;
                resp_err   <= (m.m_bresp != 2'b00) || (m.m_bid != AXI_ID);
            end
            // Flags clear on the cycle both channels finish so WR_B starts clean
            if (state == WR_AWW) begin
                aw_done <= aw_ok && !w_ok;
                w_done  <= w_ok && !aw_ok;
            end
        end
    end
endmodule
